// File: rtl/regfile_dump_reader.sv
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks every register-file entry through a combinational read
//               port after the core halts and streams it out on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halted,
  output logic [ADDR_WIDTH-1:0] ReadReg,
  input  logic [DATA_WIDTH-1:0] ReadData,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_index,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic [DATA_WIDTH-1:0] dump_cycle,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   idx_nxt;
  logic                    halted_q;
  logic [DATA_WIDTH-1:0]   cycle_cnt;
  logic                    trigger;
  logic                    start;
  logic                    capture;

  assign trigger = halted & ~halted_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      halted_q   <= 1'b0;
      cycle_cnt  <= '0;
      dump_index <= '0;
      dump_data  <= '0;
      dump_cycle <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      halted_q  <= halted;
      cycle_cnt <= cycle_cnt + DATA_WIDTH'(1);
      if (start) begin
        dump_cycle <= cycle_cnt;
      end
      // The read port is combinational, so the beat is latched in READ and
      // stays frozen for however long SEND is backpressured.
      if (capture) begin
        dump_data  <= ReadData;
        dump_index <= idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    start     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          start     = 1'b1;
          idx_nxt   = '0;
          state_nxt = READ;
        end
      end
      READ: begin
        capture   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ADDR_WIDTH'(1);
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        if (!halted) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ReadReg    = (state == IDLE) ? '0 : idx;
  assign dump_valid = (state == SEND);
  assign dump_last  = dump_valid & (dump_index == LAST_IDX);
  assign busy       = (state == READ) || (state == SEND);
  assign done       = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Directed self-checking bench for regfile_dump_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

  logic        clock;
  logic        reset;
  logic        halted;
  logic [4:0]  ReadReg;
  logic [31:0] ReadData;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        dump_last;
  logic [31:0] dump_cycle;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  int          edges;
  int          checks;
  int          errors;

  regfile_dump_reader #(
    .NUM_REGS  (32),
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .halted    (halted),
    .ReadReg   (ReadReg),
    .ReadData  (ReadData),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_index(dump_index),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .dump_cycle(dump_cycle),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register 0 reads as zero like a MIPS $zero.
  assign ReadData = (ReadReg == 5'd0) ? 32'd0 : rf[ReadReg];

  // Rising edges since reset release; equals the DUT cycle counter value.
  always @(posedge clock or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Raises halted, then follows one complete dump checking every beat.
  // mode 0: ready always high (also checks cycle timing); mode 1: ready 1-of-3.
  task automatic run_dump(input int mode, input int drop_beat, input int rerise_beat);
    int          beat;
    int          guard;
    int          e0;
    logic [31:0] exp_cyc;
    logic [31:0] exp_data;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL pre_dump_idle busy/done=%b required 00", {busy, done});
    end
    halted  = 1'b1;
    exp_cyc = 32'(edges);
    tick();
    e0 = edges;
    checks++;
    if ({busy, dump_valid, ReadReg} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL trigger_read busy=%b valid=%b ReadReg=%0d required 1 0 0",
               busy, dump_valid, ReadReg);
    end
    beat  = 0;
    guard = 0;
    while (beat < 32 && guard < 2000) begin
      dump_ready = (mode == 0) ? 1'b1 : ((guard % 3) == 0);
      if (beat == drop_beat)   halted = 1'b0;
      if (beat == rerise_beat) halted = 1'b1;
      if (dump_valid === 1'b1) begin
        exp_data = (beat == 0) ? 32'd0 : 32'h1000_0000 + 32'(beat);
        checks++;
        if ({dump_index, dump_data, dump_last, dump_cycle} !==
            {5'(beat), exp_data, (beat == 31), exp_cyc}) begin
          errors++;
          $display("FAIL beat%0d idx=%0d data=%h last=%b cyc=%0d required idx=%0d data=%h last=%b cyc=%0d",
                   beat, dump_index, dump_data, dump_last, dump_cycle,
                   beat, exp_data, (beat == 31), exp_cyc);
        end
        if (mode == 0) begin
          checks++;
          if (edges - e0 != 1 + 2 * beat) begin
            errors++;
            $display("FAIL beat%0d_timing offset=%0d required %0d", beat, edges - e0, 1 + 2 * beat);
          end
        end
        if (dump_ready) beat++;
      end else begin
        checks++;
        if (busy !== 1'b1 || ReadReg !== 5'(beat)) begin
          errors++;
          $display("FAIL read_phase%0d busy=%b ReadReg=%0d required 1 %0d", beat, busy, ReadReg, beat);
        end
      end
      tick();
      guard++;
    end
    if (beat < 32) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout beats=%0d required 32", beat);
    end
    checks++;
    if ({done, busy, dump_valid} !== 3'b100) begin
      errors++;
      $display("FAIL dump_done done/busy/valid=%b required 100", {done, busy, dump_valid});
    end
    if (mode == 0) begin
      checks++;
      if (edges - e0 != 64) begin
        errors++;
        $display("FAIL done_timing offset=%0d required 64", edges - e0);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    halted     = 1'b0;
    dump_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({ReadReg, dump_valid, dump_index, dump_data, dump_last, dump_cycle, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ReadReg=%0d valid=%b idx=%0d data=%h last=%b cyc=%0d busy=%b done=%b required all 0",
               ReadReg, dump_valid, dump_index, dump_data, dump_last, dump_cycle, busy, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, dump_valid} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle busy/done/valid=%b required 000", {busy, done, dump_valid});
    end
  endtask

  task automatic test_full_dump();
    int g;
    g = 0;
    while (edges < 100 && g < 1000) begin
      tick();
      g++;
    end
    run_dump(0, -1, -1);
    tick();
    tick();
    checks++;
    if ({done, busy, dump_cycle} !== {1'b1, 1'b0, 32'd100}) begin
      errors++;
      $display("FAIL done_hold done=%b busy=%b cyc=%0d required 1 0 100", done, busy, dump_cycle);
    end
    halted = 1'b0;
    tick();
    checks++;
    if ({done, busy, ReadReg} !== {1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL done_exit done=%b busy=%b ReadReg=%0d required 0 0 0", done, busy, ReadReg);
    end
  endtask

  task automatic test_backpressure();
    tick();
    run_dump(1, -1, -1);
    halted = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL bp_done_exit done=%b required 0", done);
    end
  endtask

  task automatic test_halt_drop();
    logic [31:0] first_cyc;
    tick();
    run_dump(0, 10, -1);
    first_cyc = dump_cycle;
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b required 0 0", done, busy);
    end
    tick();
    run_dump(0, -1, -1);
    checks++;
    if (dump_cycle == first_cyc) begin
      errors++;
      $display("FAIL new_dump_cycle cyc=%0d required not %0d", dump_cycle, first_cyc);
    end
    halted = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_dump();
    int g;
    tick();
    halted     = 1'b1;
    dump_ready = 1'b1;
    g = 0;
    while (!(dump_valid === 1'b1 && dump_index == 5'd17) && g < 200) begin
      tick();
      g++;
    end
    checks++;
    if (g >= 200) begin
      errors++;
      $display("FAIL beat17_timeout idx=%0d required 17", dump_index);
    end
    dump_ready = 1'b0;
    tick();
    checks++;
    if ({dump_valid, dump_index} !== {1'b1, 5'd17}) begin
      errors++;
      $display("FAIL beat17_hold valid=%b idx=%0d required 1 17", dump_valid, dump_index);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({ReadReg, dump_valid, dump_index, dump_data, dump_last, dump_cycle, busy, done} !== '0) begin
      errors++;
      $display("FAIL mid_reset ReadReg=%0d valid=%b idx=%0d data=%h last=%b cyc=%0d busy=%b done=%b required all 0",
               ReadReg, dump_valid, dump_index, dump_data, dump_last, dump_cycle, busy, done);
    end
    halted = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    run_dump(0, -1, -1);
    halted = 1'b0;
    tick();
  endtask

  task automatic test_halt_through_reset();
    reset  = 1'b1;
    halted = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    // Second halted edge mid-dump (low at beat 5, high again at beat 7).
    run_dump(0, 5, 7);
    checks++;
    if (dump_cycle !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_cycle cyc=%0d required 0", dump_cycle);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({done, busy, dump_valid} !== 3'b100) begin
      errors++;
      $display("FAIL no_restart done/busy/valid=%b required 100", {done, busy, dump_valid});
    end
    halted = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL fall_exit done=%b required 0", done);
    end
    run_dump(0, -1, -1);
    halted = 1'b0;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    halted     = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_halt_drop();
    test_reset_mid_dump();
    test_halt_through_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Hardware register-dump engine for the MIPS32 core's general-purpose register file. When the core halts, it walks all 32 registers through a dedicated combinational read port of the register file and streams each one out on a valid/ready interface, together with the cycle stamp of the halt. It sits beside the register file and feeds the debug/trace path, which consumes the stream.

## Interface

Parameters:
- NUM_REGS, 32: registers walked per dump, indices 0..NUM_REGS-1.
- ADDR_WIDTH, 5: register index width.
- DATA_WIDTH, 32: register and cycle-stamp width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- halted  in  1  core halted flag; a rising edge triggers a dump.
- ReadReg  out  ADDR_WIDTH  index presented to the register file dump read port.
- ReadData  in  DATA_WIDTH  combinational data returned for ReadReg in the same cycle.
- dump_valid  out  1  dump_index/dump_data/dump_last/dump_cycle are valid.
- dump_ready  in  1  consumer accepts the current beat.
- dump_index  out  ADDR_WIDTH  register index of the current beat.
- dump_data  out  DATA_WIDTH  register value of the current beat.
- dump_last  out  1  current beat is index NUM_REGS-1.
- dump_cycle  out  DATA_WIDTH  cycle counter value latched at the trigger.
- busy  out  1  a dump is in progress (states READ or SEND).
- done  out  1  dump complete, waiting for halted to drop.

## Operation

- Free-running cycle counter: cleared by reset, +1 every clock, wraps modulo 2^DATA_WIDTH.
- halted_q: registered copy of halted, reset 0. Trigger = halted & ~halted_q, honoured only in IDLE. halted high on the first cycle after reset therefore triggers a dump.
- States:
  - IDLE: on trigger, latch the cycle counter into dump_cycle, set idx=0, go to READ.
  - READ: drive ReadReg=idx. Capture ReadData into dump_data and idx into dump_index. Go to SEND.
  - SEND: dump_valid=1, with outputs held stable until dump_ready. On valid&ready: if idx==NUM_REGS-1, go to DONE; else idx+1 and go to READ.
  - DONE: done=1. When halted=0, go to IDLE.
- ReadReg equals idx in every state and is 0 in IDLE.
- Index 0 is emitted like every other index. Its data is whatever the port returns, which is 0 by construction.
- halted falling mid-dump is ignored. The dump runs to completion, then DONE exits on the first cycle that halted is 0. A new halted rising edge during READ/SEND/DONE does not restart the dump.
- dump_last = dump_valid & (dump_index==NUM_REGS-1).
- dump_cycle holds its value until the next trigger.

## Timing

- Reset values: state IDLE, ReadReg 0, dump_valid 0, dump_index 0, dump_data 0, dump_last 0, dump_cycle 0, busy 0, done 0, cycle counter 0, halted_q 0.
- Trigger sampled at edge T. READ occupies cycle T+1 (ReadReg=0). dump_valid rises at T+2 with index 0.
- With dump_ready tied high, each register takes 2 cycles (READ, SEND). The last beat is accepted at T+2*NUM_REGS. done=1 from the following cycle.
- Backpressure: any number of dump_ready=0 cycles stretches SEND. No data or index changes occur while valid&~ready.
- ReadData is sampled only in READ. Register-file writes during the dump are not expected while halted. Any such write is reflected only if it lands before that index's READ cycle.
- Reset asserted mid-dump aborts immediately to reset values. No partial beat is completed.

## Test plan

- Preload R1..R31 with 0x1000_0000+i, raise halted at cycle 100, dump_ready=1 -> 32 beats: index 0 data 0, index i data 0x1000_0000+i; dump_last only on index 31; dump_cycle=100; done high at trigger+65 cycles.
- Same preload, dump_ready toggling 1-of-3 cycles -> identical beat sequence; outputs stable whenever valid&~ready; no beat duplicated or dropped.
- Drop halted at beat 10 -> all 32 beats still emitted; done pulses for one cycle, then IDLE; raising halted again starts a new dump with a new dump_cycle.
- Assert reset during beat 17 (valid&~ready) -> all outputs 0 next cycle, state IDLE; a subsequent halted edge produces a full 0..31 dump.
- Hold halted high through reset release -> dump triggers on the first post-reset cycle with dump_cycle=0; a second edge during DONE is ignored until halted falls.
